// File: rtl/mine_placer.sv
// mine_placer: builds the 25-bit mine bitmap for the 5x5 minesweeper board.
// A free-running 16-bit Fibonacci LFSR supplies candidate cell indices; on
// start, MINE_COUNT distinct cells are set and place_done is raised.
// All state updates on the falling edge of clka, matching the datapath phase.
// Optional feature macro: MINE_PLACER_SAFE_CELL_EN (safe_cell is never mined).
// Handshake: start is level-sampled in IDLE/DONE and ignored in PLACE; the
// consumer treats place_done high as "mines valid and frozen", and busy high
// as "placement in progress". busy/place_done together expose the FSM state
// (00 = IDLE, 10 = PLACE, 01 = DONE).
`timescale 1ns/1ps
module mine_placer #(
  parameter int          MINE_COUNT   = 5,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic        start,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic [4:0]  safe_cell,
  output logic [24:0] mines,
  output logic        busy,
  output logic        place_done
);

  generate
    if (MINE_COUNT < 1 || MINE_COUNT > 24) begin : g_bad_mine_count
      $error("mine_placer: MINE_COUNT must be in 1..24");
    end
  endgenerate

  localparam logic [4:0] MINE_TARGET = 5'(MINE_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLACE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] mines_q, mines_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  cand;
  logic [24:0] cand_bit;
  logic        safe_ok;
  logic        accept;

  assign cand     = lfsr_q[4:0];
  // Shifting past bit 24 yields zero, so out-of-board candidates map to no bit.
  assign cand_bit = 25'd1 << cand;

`ifdef MINE_PLACER_SAFE_CELL_EN
  assign safe_ok = (cand != safe_cell);
`else
  logic unused_safe_cell;
  assign unused_safe_cell = ^safe_cell;
  assign safe_ok = 1'b1;
`endif

  assign accept = (state_q == S_PLACE) && (cand < 5'd25) &&
                  ((mines_q & cand_bit) == 25'd0) && safe_ok;

  // LFSR: seed load overrides the advance; a zero seed would lock it, so swap in the default.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (seed_load) begin
      lfsr_d = (seed == 16'd0) ? SEED_DEFAULT : seed;
    end
  end

  // Next-state, bitmap and mine-count logic for IDLE -> PLACE -> DONE.
  always_comb begin
    state_d = state_q;
    mines_d = mines_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mines_d = 25'd0;
          count_d = 5'd0;
          state_d = S_PLACE;
        end
      end
      S_PLACE: begin
        if (accept) begin
          mines_d = mines_q | cand_bit;
          count_d = count_q + 5'd1;
          if (count_q + 5'd1 == MINE_TARGET) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, bitmap, LFSR and registered status decodes, all on the falling edge.
  always_ff @(negedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q    <= S_IDLE;
      mines_q    <= 25'd0;
      count_q    <= 5'd0;
      lfsr_q     <= SEED_DEFAULT;
      busy       <= 1'b0;
      place_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      mines_q    <= mines_d;
      count_q    <= count_d;
      lfsr_q     <= lfsr_d;
      busy       <= (state_d == S_PLACE);
      place_done <= (state_d == S_DONE);
    end
  end

  assign mines = mines_q;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: table-driven placements, hand sequences for reset,
// replay and rejection, and randomized runs checked against a behavioural
// model of the candidate stream and the set of occupied cells.
`timescale 1ns/1ps
module tb_mine_placer;

  localparam int MC   = 5;
  localparam int MC24 = 24;
  localparam logic [4:0] SAFE = 5'd12;
`ifdef MINE_PLACER_SAFE_CELL_EN
  localparam bit SAFE_EN = 1'b1;
  localparam int N24     = 200;
`else
  localparam bit SAFE_EN = 1'b0;
  localparam int N24     = 60;
`endif

  logic        clka;
  logic        restart_n;
  logic        start;
  logic        seed_load;
  logic [15:0] seed;
  logic [4:0]  safe_cell;
  logic [24:0] mines, mines24;
  logic        busy, busy24;
  logic        place_done, done24;

  int n_tests;
  int n_fail;

  mine_placer #(.MINE_COUNT(MC)) dut (
    .clka(clka), .restart_n(restart_n), .start(start), .seed_load(seed_load),
    .seed(seed), .safe_cell(safe_cell), .mines(mines), .busy(busy),
    .place_done(place_done)
  );

  mine_placer #(.MINE_COUNT(MC24)) dut24 (
    .clka(clka), .restart_n(restart_n), .start(start), .seed_load(seed_load),
    .seed(seed), .safe_cell(safe_cell), .mines(mines24), .busy(busy24),
    .place_done(done24)
  );

  // ---------------- clock / reset ----------------
  initial clka = 1'b0;
  always #5 clka = ~clka;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Model LFSR: follows the spec's update rule from the driven inputs.
  logic [15:0] m_lfsr;
  always @(negedge clka or negedge restart_n) begin
    if (!restart_n)     m_lfsr <= 16'hACE1;
    else if (seed_load) m_lfsr <= (seed == 16'd0) ? 16'hACE1 : seed;
    else                m_lfsr <= lfsr_step(m_lfsr);
  end

  // Whole-placement prediction from the first candidate's LFSR value.
  function automatic void predict(input logic [15:0] s, input int mc,
                                  output logic [24:0] m, output int cyc);
    logic [15:0] l;
    bit taken[25];
    int placed;
    int c;
    l = s; placed = 0; cyc = 0; m = '0;
    foreach (taken[i]) taken[i] = 1'b0;
    while (placed < mc && cyc < 100000) begin
      c = int'(l[4:0]);
      if (c < 25 && !taken[c] && !(SAFE_EN && c == int'(SAFE))) begin
        taken[c] = 1'b1;
        placed++;
      end
      cyc++;
      l = lfsr_step(l);
    end
    foreach (taken[i]) m[i] = taken[i];
  endfunction

  // Seed whose first five candidates contain 27 and a repeated on-board index.
  function automatic logic [15:0] find_reject_seed();
    logic [15:0] l;
    bit seen[25];
    bit has27, dup;
    int c;
    for (int s = 1; s < 65536; s++) begin
      l = 16'(s); has27 = 1'b0; dup = 1'b0;
      foreach (seen[i]) seen[i] = 1'b0;
      for (int k = 0; k < 5; k++) begin
        c = int'(l[4:0]);
        if (c == 27) has27 = 1'b1;
        else if (c < 25) begin
          if (seen[c]) dup = 1'b1;
          seen[c] = 1'b1;
        end
        l = lfsr_step(l);
      end
      if (has27 && dup) return 16'(s);
    end
    return 16'd0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic kick(input bit load, input logic [15:0] s);
    start = 1'b1; seed_load = load; seed = s;
    @(posedge clka);
    start = 1'b0; seed_load = 1'b0;
  endtask

  // Follow one placement cycle by cycle against the set-of-cells model.
  task automatic run_check(input string name, input bit rnd_start, input bit rnd_seed,
                           output int cycles, output logic [24:0] final_m);
    bit taken[25];
    int placed;
    int c;
    bit acc;
    logic [24:0] em;
    placed = 0; cycles = 0; em = '0;
    foreach (taken[i]) taken[i] = 1'b0;
    chk({name, "_entry"}, 32'({busy, place_done, mines}), 32'({1'b1, 1'b0, 25'd0}));
    while (placed < MC && cycles < 2000) begin
      c   = int'(m_lfsr[4:0]);
      acc = (c < 25) && !taken[c] && !(SAFE_EN && c == int'(SAFE));
      start = rnd_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (rnd_seed && $urandom_range(0, 7) == 0) begin
        seed_load = 1'b1;
        seed      = 16'($urandom);
      end else begin
        seed_load = 1'b0;
      end
      @(posedge clka);
      cycles++;
      if (acc) begin
        taken[c] = 1'b1;
        em[c]    = 1'b1;
        placed++;
      end
      chk({name, "_step"}, 32'({busy, place_done, mines}),
          32'({placed < MC, placed == MC, em}));
    end
    start = 1'b0; seed_load = 1'b0;
    if (placed < MC) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: placed %0d required %0d", name, placed, MC);
    end
    final_m = mines;
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [24:0] exp_mines;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc;
    int pcyc;
    logic [24:0] fm;
    logic [24:0] pm;
    logic [15:0] rs;
    bit seen12;
    int w;

    n_tests = 0; n_fail = 0;
    start = 1'b0; seed_load = 1'b0; seed = 16'd0; safe_cell = SAFE;
    restart_n = 1'b0;
    repeat (2) @(posedge clka);
    chk("reset_outputs",   32'({busy, place_done, mines}), 32'd0);
    chk("reset_outputs24", 32'({busy24, done24, mines24}), 32'd0);
    restart_n = 1'b1;
    @(posedge clka);

    // Table: seed 1 by hand (candidates 1,2,4,8,16), the rest from the model.
    vecs[0] = '{16'h0001, 25'h0010116, 5};
    predict(16'hACE1, MC, pm, pcyc); vecs[1] = '{16'h0000, pm, pcyc};
    vecs[2] = '{16'hACE1, pm, pcyc};
    for (int i = 3; i < 8; i++) begin
      vecs[i].seed = 16'($urandom);
      predict((vecs[i].seed == 16'd0) ? 16'hACE1 : vecs[i].seed, MC, pm, pcyc);
      vecs[i].exp_mines = pm; vecs[i].exp_cycles = pcyc;
    end
    for (int i = 0; i < 8; i++) begin
      kick(1'b1, vecs[i].seed);
      run_check($sformatf("vec%0d", i), 1'b0, 1'b0, cyc, fm);
      chk($sformatf("vec%0d_mines", i), 32'(fm), 32'(vecs[i].exp_mines));
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      chk($sformatf("vec%0d_popcount", i), 32'($countones(fm)), 32'(MC));
    end

    // Rejections: out-of-board 27 and a repeat stretch latency past 5 cycles.
    rs = find_reject_seed();
    if (rs == 16'd0) begin
      n_tests++; n_fail++;
      $display("FAIL rej_seed_search: got none required a seed");
    end else begin
      predict(rs, MC, pm, pcyc);
      kick(1'b1, rs);
      run_check("reject", 1'b0, 1'b0, cyc, fm);
      chk("reject_cycles", 32'(cyc), 32'(pcyc));
      chk("reject_latency_gt5", 32'(cyc > 5), 32'd1);
      chk("reject_mines", 32'(fm), 32'(pm));
    end

    // DONE holds mines frozen, then replay with start noise during PLACE.
    repeat (3) @(posedge clka);
    chk("done_frozen", 32'({busy, place_done, mines}), 32'({1'b0, 1'b1, fm}));
    for (int r = 0; r < 4; r++) begin
      kick(1'b0, 16'd0);
      run_check($sformatf("replay%0d", r), 1'b1, 1'b0, cyc, fm);
      chk($sformatf("replay%0d_popcount", r), 32'($countones(fm)), 32'(MC));
    end

    // Random seeds, including seed loads in the middle of placement.
    for (int r = 0; r < 8; r++) begin
      kick(1'($urandom_range(0, 1)), 16'($urandom));
      run_check($sformatf("rand%0d", r), 1'b1, 1'b1, cyc, fm);
      chk($sformatf("rand%0d_popcount", r), 32'($countones(fm)), 32'(MC));
    end

    // Asynchronous abort mid-PLACE, then first run from the reset LFSR value.
    kick(1'b1, 16'h0001);
    repeat (2) @(posedge clka);
    restart_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({busy, place_done, mines}), 32'd0);
    @(posedge clka);
    restart_n = 1'b1;
    kick(1'b0, 16'd0);
    run_check("after_reset", 1'b0, 1'b0, cyc, fm);
    predict(lfsr_step(16'hACE1), MC, pm, pcyc);
    chk("after_reset_mines", 32'(fm), 32'(pm));
    chk("after_reset_cycles", 32'(cyc), 32'(pcyc));

    // Full-board runs with 24 mines.
    seen12 = 1'b0;
    for (int r = 0; r < N24; r++) begin
      rs = 16'($urandom);
      kick(1'b1, rs);
      w = 0;
      while (!done24 && w < 4000) begin
        @(posedge clka);
        w++;
      end
      if (!done24) begin
        n_tests++; n_fail++;
        $display("FAIL mc24_timeout run %0d: place_done 0 required 1", r);
      end
      predict((rs == 16'd0) ? 16'hACE1 : rs, MC24, pm, pcyc);
      chk($sformatf("mc24_mines%0d", r), 32'(mines24), 32'(pm));
      chk($sformatf("mc24_popcount%0d", r), 32'($countones(mines24)), 32'(MC24));
`ifdef MINE_PLACER_SAFE_CELL_EN
      chk($sformatf("mc24_safe%0d", r), 32'(mines24), 32'h01FFEFFF);
`endif
      if (mines24[12]) seen12 = 1'b1;
    end
`ifndef MINE_PLACER_SAFE_CELL_EN
    chk("mc24_bit12_seen", 32'(seen12), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
